// File: rtl/midi_voice_allocator.sv
// MIDI byte-stream parser (one channel, running status) feeding a voice pool
// with free-first allocation, oldest-voice stealing and CC 7 / CC 123 handling.
module midi_voice_allocator #(
    parameter int NUM_VOICES   = 4,
    parameter int MIDI_CHANNEL = 0,
    parameter int OMNI         = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rx_valid_i,
    input  logic [7:0]              rx_data_i,
    output logic [NUM_VOICES-1:0]   voice_gate_o,
    output logic [7*NUM_VOICES-1:0] voice_note_o,
    output logic [7*NUM_VOICES-1:0] voice_vel_o,
    output logic [6:0]              volume_o,
    output logic                    voice_event_o,
    output logic [2:0]              voice_event_idx_o
);
    // state  | meaning
    // IDLE   | no running status, data bytes dropped
    // SKIP   | status not for us, data bytes dropped until next status
    // WAIT1  | accepted status, expecting first data byte
    // WAIT2  | first data byte latched, expecting second
    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_WAIT1, S_WAIT2} state_t;

    localparam int AW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AW-1:0] AGE_MAX = AW'(NUM_VOICES - 1);

    state_t      state_q, state_d;
    logic [3:0]  rs_type_q, rs_type_d;
    logic [6:0]  d1_q, d1_d;
    logic        ex_vld_q, ex_vld_d;
    logic [3:0]  ex_type_q, ex_type_d;
    logic [6:0]  ex_d1_q, ex_d1_d, ex_d2_q, ex_d2_d;

    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [6:0]    note_q [NUM_VOICES];
    logic [6:0]    note_d [NUM_VOICES];
    logic [6:0]    vel_q  [NUM_VOICES];
    logic [6:0]    vel_d  [NUM_VOICES];
    logic [AW-1:0] age_q  [NUM_VOICES];
    logic [AW-1:0] age_d  [NUM_VOICES];
    logic [6:0]    volume_q, volume_d;
    logic          event_q, event_d;
    logic [2:0]    event_idx_q, event_idx_d;

    logic accept;
    assign accept = ((OMNI != 0) || (rx_data_i[3:0] == 4'(MIDI_CHANNEL))) &&
                    ((rx_data_i[7:4] == 4'h8) || (rx_data_i[7:4] == 4'h9) ||
                     (rx_data_i[7:4] == 4'hB));

    always_comb begin
        state_d   = state_q;
        rs_type_d = rs_type_q;
        d1_d      = d1_q;
        ex_vld_d  = 1'b0;
        ex_type_d = ex_type_q;
        ex_d1_d   = ex_d1_q;
        ex_d2_d   = ex_d2_q;
        if (rx_valid_i) begin
            if (rx_data_i[7:4] == 4'hF) begin
                // realtime (F8-FF) falls through untouched
                if (!rx_data_i[3]) begin
                    rs_type_d = 4'h0;
                    state_d   = S_SKIP;
                end
            end else if (rx_data_i[7]) begin
                rs_type_d = rx_data_i[7:4];
                state_d   = accept ? S_WAIT1 : S_SKIP;
            end else begin
                case (state_q)
                    S_WAIT1: begin
                        d1_d    = rx_data_i[6:0];
                        state_d = S_WAIT2;
                    end
                    S_WAIT2: begin
                        ex_vld_d  = 1'b1;
                        ex_type_d = rs_type_q;
                        ex_d1_d   = d1_q;
                        ex_d2_d   = rx_data_i[6:0];
                        state_d   = S_WAIT1;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic          is_on, is_off, is_cc;
    logic          hit_found, free_found, off_any;
    int            hit_idx, free_idx, steal_idx, sel_idx, off_idx;
    logic [AW-1:0] best_age;

    assign is_on  = ex_vld_q && (ex_type_q == 4'h9) && (ex_d2_q != 7'd0);
    assign is_off = ex_vld_q && ((ex_type_q == 4'h8) ||
                                 ((ex_type_q == 4'h9) && (ex_d2_q == 7'd0)));
    assign is_cc  = ex_vld_q && (ex_type_q == 4'hB);

    always_comb begin
        gate_d      = gate_q;
        note_d      = note_q;
        vel_d       = vel_q;
        age_d       = age_q;
        volume_d    = volume_q;
        event_d     = 1'b0;
        event_idx_d = event_idx_q;
        hit_found   = 1'b0;
        free_found  = 1'b0;
        off_any     = 1'b0;
        hit_idx     = 0;
        free_idx    = 0;
        steal_idx   = 0;
        off_idx     = 0;
        best_age    = age_q[0];
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (gate_q[i] && (note_q[i] == ex_d1_q) && !hit_found) begin
                hit_found = 1'b1;
                hit_idx   = i;
            end
            if (!gate_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = i;
            end
            // strict compare keeps the lowest index on equal ages
            if (age_q[i] > best_age) begin
                best_age  = age_q[i];
                steal_idx = i;
            end
        end
        sel_idx = hit_found ? hit_idx : (free_found ? free_idx : steal_idx);

        if (is_on) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (i == sel_idx) begin
                    gate_d[i] = 1'b1;
                    note_d[i] = ex_d1_q;
                    vel_d[i]  = ex_d2_q;
                    age_d[i]  = '0;
                end else if (gate_q[i] && (age_q[i] != AGE_MAX)) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
            event_d     = 1'b1;
            event_idx_d = 3'(sel_idx);
        end else if (is_off) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (gate_q[i] && (note_q[i] == ex_d1_q)) begin
                    gate_d[i] = 1'b0;
                    if (!off_any) begin
                        off_any = 1'b1;
                        off_idx = i;
                    end
                end
            end
            if (off_any) begin
                event_d     = 1'b1;
                event_idx_d = 3'(off_idx);
            end
        end else if (is_cc) begin
            if (ex_d1_q == 7'd7) begin
                volume_d = ex_d2_q;
            end else if (ex_d1_q == 7'd123) begin
                gate_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rs_type_q   <= 4'h0;
            d1_q        <= 7'd0;
            ex_vld_q    <= 1'b0;
            ex_type_q   <= 4'h0;
            ex_d1_q     <= 7'd0;
            ex_d2_q     <= 7'd0;
            gate_q      <= '0;
            volume_q    <= 7'h64;
            event_q     <= 1'b0;
            event_idx_q <= 3'd0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= 7'd0;
                vel_q[i]  <= 7'd0;
                age_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            rs_type_q   <= rs_type_d;
            d1_q        <= d1_d;
            ex_vld_q    <= ex_vld_d;
            ex_type_q   <= ex_type_d;
            ex_d1_q     <= ex_d1_d;
            ex_d2_q     <= ex_d2_d;
            gate_q      <= gate_d;
            volume_q    <= volume_d;
            event_q     <= event_d;
            event_idx_q <= event_idx_d;
            note_q      <= note_d;
            vel_q       <= vel_d;
            age_q       <= age_d;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
        assign voice_note_o[7*g +: 7] = note_q[g];
        assign voice_vel_o[7*g +: 7]  = vel_q[g];
    end
    assign voice_gate_o      = gate_q;
    assign volume_o          = volume_q;
    assign voice_event_o     = event_q;
    assign voice_event_idx_o = event_idx_q;

endmodule

// File: doc/midi_voice_allocator.md
# midi_voice_allocator

Controller between the MIDI UART byte receiver and the synthesizer voice datapath. It parses the received MIDI byte stream, including running status, for one channel. It then schedules Note On/Off events onto a fixed pool of voices, using free-voice-first allocation and oldest-voice stealing. It also keeps the master volume from Control Change 7 and handles All Notes Off (CC 123).

## Interface
- NUM_VOICES, 4, number of voice slots; legal range 2–8.
- MIDI_CHANNEL, 0, 4-bit channel number accepted (0 = MIDI channel 1).
- OMNI, 0, when 1, channel-voice messages on every channel are accepted.
- clk  in  1  system clock (25 MHz in this design).
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a complete received byte.
- rx_data  in  8  received MIDI byte.
- voice_gate  out  NUM_VOICES  bit i = voice i is sounding.
- voice_note  out  7*NUM_VOICES  voice i note number at bits [7i+6:7i].
- voice_vel  out  7*NUM_VOICES  voice i velocity at bits [7i+6:7i].
- volume  out  7  master volume (CC 7).
- voice_event  out  1  one-cycle pulse on any voice assignment or release.
- voice_event_idx  out  3  index of the voice that voice_event refers to.

## Operation
**Byte classes**
- 0xF8–0xFF (realtime): ignored entirely. Parser state, running status and data count are untouched.
- 0xF0–0xF7 (system common/SysEx): clear running status. Parser enters SKIP, which drops data bytes until the next status byte.
- 0x80–0xEF: load the running status register.
  - Matching channel (or OMNI) and type 0x8/0x9/0xB: parser goes to WAIT1.
  - Any other channel or type: parser goes to SKIP.
- Data bytes (bit 7 = 0): handled per parser state.

**Parser states**
- IDLE: data byte is dropped.
- SKIP: data byte is dropped.
- WAIT1: latch d1; go to WAIT2.
- WAIT2: latch d2; execute the message; return to WAIT1 (running status), ready for the next d1.
- Every accepted channel type used here has two data bytes.

**Message execution**
- Note On with d2 = 0 is treated as Note Off.
- Note On, d2 > 0, priority order:
  1. A gated voice already holds note d1: retrigger that voice. Velocity becomes d2; its age is reset.
  2. Otherwise, the lowest-index voice with gate = 0.
  3. Otherwise, steal the voice with the largest age. Ties go to the lowest index.
- The chosen voice gets gate = 1, note = d1, vel = d2, age = 0.
- Every other gated voice increments its age, saturating at NUM_VOICES−1.
- Note Off: every gated voice with note == d1 gets gate = 0. Note and vel are retained for release envelopes.
  - voice_event_idx reports the lowest matching index.
  - No match: no change and no event.
- CC 7: volume ← d2.
- CC 123: all gates ← 0. No voice_event.
- Any other CC: ignored.
- Age counters are ceil(log2(NUM_VOICES)) bits wide.

## Timing
- Reset values:
  - Parser in IDLE; running status cleared.
  - voice_gate, voice_note, voice_vel and ages all 0.
  - volume = 100 (7'h64).
  - voice_event = 0; voice_event_idx = 0.
- Latency: one cycle. Voice outputs and voice_event update on the first clk edge after the edge that samples the final data byte's rx_valid.
- voice_event is high for exactly one cycle per executed Note On or effective Note Off.
- Back-to-back bytes: rx_valid may be high on consecutive cycles. The block must sustain one byte per cycle with no stall and no input ready signal.
- rx_valid is ignored in any cycle where rst = 1.
- Reset mid-message discards the partial message and clears running status.
- A status byte arriving in WAIT2 aborts the pending message; the new status takes over.
- A realtime byte between d1 and d2 does not break the message.

## Test plan
- Note On sequence:
  - Send 0x90 0x3C 0x64 → voice 0 gate = 1, note = 0x3C, vel = 0x64; voice_event pulse with idx 0 one cycle after the last byte.
  - Then send running-status bytes 0x40 0x50 → voice 1 gets note 0x40.
- Note Off: send 0x90 0x3C 0x00, then 0x80 0x40 0x10 → voices 0 and 1 gate = 0; notes are retained; two event pulses with idx 0 and idx 1.
- Stealing (NUM_VOICES = 4): play notes 60, 61, 62, 63, then 64 → note 64 replaces note 60 in voice 0. Replay 61 → it retriggers voice 1 with no steal.
- Channel filter:
  - With MIDI_CHANNEL = 0, send 0x91 0x3C 0x64 → no change.
  - Send 0xB0 0x07 0x20 → volume = 0x20.
  - Send 0xB0 0x7B 0x00 → all gates = 0.
- Interruptions:
  - 0x90 0x3C 0xF8 0x64 → note plays (realtime byte is transparent).
  - 0x90 0x3C 0xF0 0x64 → nothing plays; the trailing 0x64 is dropped.
- Reset asserted between d1 and d2 → outputs return to reset values. A following lone 0x64 is dropped.
